// File: rtl/rx_clock.sv
// -----------------------------------------------------------------------------
// rx_clock -- receive-side emulated clock.
//
// Keeps the emulated time of this clock's next edge and fires an edge when
// the global time manager announces that time (time_next == time_clock).
// Each edge advances the edge time by
//   period_eff = max(PERIOD_MIN, period_nom + jit + pending CDR update),
// which lets the CDR loop steer RX sampling one phase step at a time.
//
// Optional feature macro: RX_CLOCK_JITTER_EN
//   defined   : a Fibonacci LFSR supplies a signed jitter sample that is
//               scaled by jitter_scale (fixed point) and added per edge.
//   undefined : no LFSR, jitter is zero and jitter_scale is ignored.
//
// Ports
//   clk           in   system clock
//   rst           in   synchronous, active-high reset
//   time_next     in   global emulated time of the next event
//   period_nom    in   nominal RX period (unsigned)
//   jitter_scale  in   jitter amplitude, JITTER_SCALE_POINT fractional bits
//   upd_data      in   signed CDR phase update
//   upd_valid     in   update offered
//   upd_ready     out  update slot free (no update pending, not in reset)
//   time_clock    out  emulated time of this clock's next edge
//   time_eq       out  time_next == time_clock (combinational, 0 in reset)
//   cke_out       out  edge enable, asserted on every Nth edge (combinational)
// -----------------------------------------------------------------------------
`default_nettype none

module rx_clock #(
  parameter int TIME_WIDTH         = 32,
  parameter int PERIOD_WIDTH       = 16,
  parameter int JITTER_WIDTH       = 8,
  parameter int UPDATE_WIDTH       = 10,
  parameter int JITTER_LFSR_WIDTH  = 16,
  parameter int JITTER_SCALE_WIDTH = 8,
  parameter int JITTER_SCALE_POINT = 8,
  parameter int LFSR_INIT          = 3,
  parameter int N                  = 1,
  parameter int PERIOD_MIN         = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [TIME_WIDTH-1:0]         time_next,
  input  logic [PERIOD_WIDTH-1:0]       period_nom,
  input  logic [JITTER_SCALE_WIDTH-1:0] jitter_scale,
  input  logic [UPDATE_WIDTH-1:0]       upd_data,
  input  logic                          upd_valid,
  output logic                          upd_ready,
  output logic [TIME_WIDTH-1:0]         time_clock,
  output logic                          time_eq,
  output logic                          cke_out
);

  // Period arithmetic width: wide enough that nominal + jitter + update can
  // neither overflow nor lose its sign before the lower clamp is applied.
  localparam int SUM_W = PERIOD_WIDTH + UPDATE_WIDTH + 2;
  localparam int DIV_W = (N > 1) ? $clog2(N) : 1;

  localparam logic signed [SUM_W-1:0] PMIN_S  = SUM_W'(PERIOD_MIN);
  localparam logic [DIV_W-1:0]        DIV_TOP = DIV_W'(N - 1);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Lower clamp of the effective period. The signed sum can go to zero or
  // negative for large negative CDR updates; the edge must still move forward.
  function automatic logic [SUM_W-1:0] sat_period(input logic signed [SUM_W-1:0] s);
    if (s < PMIN_S) begin
      return PMIN_S;
    end
    return s;
  endfunction

  // Signed jitter sample times unsigned fixed-point scale, then an arithmetic
  // right shift to drop the fractional bits (rounds toward minus infinity).
  localparam int PROD_W = JITTER_WIDTH + JITTER_SCALE_WIDTH + 1;

  function automatic logic signed [SUM_W-1:0] scale_jitter(
    input logic [JITTER_WIDTH-1:0]       sample,
    input logic [JITTER_SCALE_WIDTH-1:0] scale
  );
    logic signed [PROD_W-1:0] a;
    logic signed [PROD_W-1:0] b;
    logic signed [PROD_W-1:0] prod;
    a    = PROD_W'($signed(sample));
    b    = PROD_W'(scale);
    prod = a * b;
    return SUM_W'(prod >>> JITTER_SCALE_POINT);
  endfunction

  // Maximal-length Fibonacci tap masks for the common lengths. Other lengths
  // fall back to x^n + x^(n-1) + 1, which is maximal for several small n.
  function automatic logic [JITTER_LFSR_WIDTH-1:0] lfsr_taps(input int len);
    case (len)
      8:       return JITTER_LFSR_WIDTH'(32'h0000_00B8);
      16:      return JITTER_LFSR_WIDTH'(32'h0000_D008);
      24:      return JITTER_LFSR_WIDTH'(32'h00E1_0000);
      32:      return JITTER_LFSR_WIDTH'(32'h8020_0003);
      default: return JITTER_LFSR_WIDTH'(3) << (len - 2);
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [TIME_WIDTH-1:0]   time_clock_q, time_clock_d;
  logic                    pend_q,       pend_d;
  logic [UPDATE_WIDTH-1:0] pend_upd_q,   pend_upd_d;
  logic [DIV_W-1:0]        div_cnt_q,    div_cnt_d;

  logic                    edge_fire;
  logic                    upd_accept;
  logic signed [SUM_W-1:0] nom_s;
  logic signed [SUM_W-1:0] jit_s;
  logic signed [SUM_W-1:0] upd_s;
  logic signed [SUM_W-1:0] sum_s;
  logic [SUM_W-1:0]        period_eff;

  // ---------------------------------------------------------------------------
  // Outputs and edge detection (combinational, zero latency)
  // ---------------------------------------------------------------------------
  assign time_eq    = !rst && (time_next == time_clock_q);
  assign edge_fire  = time_eq;
  assign cke_out    = edge_fire && (div_cnt_q == '0);
  assign upd_ready  = !rst && !pend_q;
  assign upd_accept = upd_valid && upd_ready;
  assign time_clock = time_clock_q;

  // ---------------------------------------------------------------------------
  // Jitter source
  // ---------------------------------------------------------------------------
`ifdef RX_CLOCK_JITTER_EN
  localparam logic [JITTER_LFSR_WIDTH-1:0] TAPS = lfsr_taps(JITTER_LFSR_WIDTH);

  logic [JITTER_LFSR_WIDTH-1:0] lfsr_q, lfsr_d;

  // The LFSR only advances on an edge, so the jitter sequence is tied to the
  // edge count rather than to the system clock.
  always_comb begin
    lfsr_d = lfsr_q;
    if (edge_fire) begin
      lfsr_d = {lfsr_q[JITTER_LFSR_WIDTH-2:0], ^(lfsr_q & TAPS)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= JITTER_LFSR_WIDTH'(LFSR_INIT);
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign jit_s = scale_jitter(lfsr_q[JITTER_WIDTH-1:0], jitter_scale);
`else
  // Jitter disabled: scale input and jitter configuration have no effect.
  logic unused_jitter_sink;
  assign unused_jitter_sink = ^{jitter_scale,
                                1'(LFSR_INIT + JITTER_LFSR_WIDTH + JITTER_SCALE_POINT + JITTER_WIDTH),
                                lfsr_taps(JITTER_LFSR_WIDTH),
                                scale_jitter('0, '0)};
  assign jit_s = '0;
`endif

  // ---------------------------------------------------------------------------
  // Effective period
  // ---------------------------------------------------------------------------
  // A pending update is only ever applied on an edge after its accept cycle:
  // accept requires pend_q == 0, so an update accepted on an edge cycle is not
  // yet visible in pend_q and that edge uses the plain period.
  assign nom_s      = $signed({{(SUM_W - PERIOD_WIDTH){1'b0}}, period_nom});
  assign upd_s      = pend_q ? SUM_W'($signed(pend_upd_q)) : '0;
  assign sum_s      = nom_s + jit_s + upd_s;
  assign period_eff = sat_period(sum_s);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    time_clock_d = time_clock_q;
    pend_d       = pend_q;
    pend_upd_d   = pend_upd_q;
    div_cnt_d    = div_cnt_q;

    if (edge_fire) begin
      // Modular add: emulated time wraps at 2^TIME_WIDTH.
      time_clock_d = time_clock_q + TIME_WIDTH'(period_eff);
      div_cnt_d    = (div_cnt_q == DIV_TOP) ? '0 : div_cnt_q + DIV_W'(1);
      if (pend_q) begin
        pend_d = 1'b0;
      end
    end

    // Accept and consume are mutually exclusive (accept needs pend_q == 0,
    // consume needs pend_q == 1), so the order here is not significant.
    if (upd_accept) begin
      pend_d     = 1'b1;
      pend_upd_d = upd_data;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // Reset restarts emulated time one nominal period out and drops any
  // pending CDR update.
  always_ff @(posedge clk) begin
    if (rst) begin
      time_clock_q <= TIME_WIDTH'(period_nom);
      pend_q       <= 1'b0;
      pend_upd_q   <= '0;
      div_cnt_q    <= '0;
    end else begin
      time_clock_q <= time_clock_d;
      pend_q       <= pend_d;
      pend_upd_q   <= pend_upd_d;
      div_cnt_q    <= div_cnt_d;
    end
  end

endmodule

`default_nettype wire
